// File: rtl/frame_stream_if.sv
// AXI-Stream style frame bus carrying samples with tuser on the first beat
// and tlast on the last beat.
interface frame_stream_if #(
    parameter int unsigned DW = 16
);
    logic [DW-1:0] tdata_m;
    logic          tuser_m;
    logic          tlast_m;
    logic          tvalid_m;
    logic          tready_m;

    modport master (
        output tdata_m,
        output tuser_m,
        output tlast_m,
        output tvalid_m,
        input  tready_m
    );

    modport slave (
        input  tdata_m,
        input  tuser_m,
        input  tlast_m,
        input  tvalid_m,
        output tready_m
    );
endinterface

// File: rtl/frame_stream_source.sv
// Frame stream source: a write port fills a ping-pong pair of BRAM banks and
// each completed bank is replayed as one stream frame with back-pressure.
// Optional feature macro: FRAME_SOURCE_PATTERN_EN (adds pattern_en input that
// replaces BRAM data with a triangular test ramp).
module frame_stream_source #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    input  logic          wr_last,
    output logic          wr_ready,
    frame_stream_if.master m_axis,
    input  logic          start_oneshot,
    input  logic          start_cont,
`ifdef FRAME_SOURCE_PATTERN_EN
    input  logic          pattern_en,
`endif
    output logic          busy,
    output logic          frame_done,
    output logic          overflow,
    input  logic          clr_overflow
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAITF  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    // Bank storage, addressed as {bank, word}
    logic [DW-1:0] r_mem [0:2*DEPTH-1];

    // Write-side state
    logic          r_wbank;
    logic [AW-1:0] r_wa;
    logic [1:0]    r_full;
    logic [LW-1:0] r_len [0:1];
    logic          r_overflow;
    logic          r_wr_ready;

    // Read-side state
    state_t        r_state;
    logic          r_rbank;
    logic [LW-1:0] r_ra;
    logic          r_busy;
    logic          r_frame_done;
    logic [DW-1:0] r_rd_raw;
    logic          r_rd_vld;
    logic          r_rd_user;
    logic          r_rd_last;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_out_user;
    logic          r_out_last;
    logic          r_skid_valid;
    logic [DW-1:0] r_skid_data;
    logic          r_skid_user;
    logic          r_skid_last;

    logic          w_wr_fire;
    logic          w_wr_drop;
    logic          w_wr_done;
    logic          w_pop;
    logic          w_release;
    logic [1:0]    w_full_nxt;
    logic          w_wbank_nxt;
    logic [1:0]    w_occ;
    logic          w_rd_issue;
    logic [DW-1:0] w_rd_data;

    assign w_wr_fire = ce & wr_valid & r_wr_ready;
    assign w_wr_drop = ce & wr_valid & ~r_wr_ready;
    assign w_wr_done = w_wr_fire & (wr_last | (&r_wa));
    assign w_pop     = r_out_valid & m_axis.tready_m;
    assign w_release = ce & w_pop & r_out_last;

    // Slots committed after this cycle: buffered beats plus read in flight, minus a pop
    assign w_occ      = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_rd_vld) - 2'(w_pop);
    assign w_rd_issue = (r_state == S_STREAM) && (r_ra < r_len[r_rbank]) && (w_occ < 2'd2);

`ifdef FRAME_SOURCE_PATTERN_EN
    logic          r_rd_pat;
    logic [DW-1:0] r_rd_patval;
    logic [LW-1:0] w_half;
    logic [LW-1:0] w_pat;

    // Triangle ramp: rises to len/2 then falls by one per beat
    assign w_half    = r_len[r_rbank] >> 1;
    assign w_pat     = (r_ra <= w_half) ? r_ra : ((w_half << 1) - r_ra);
    assign w_rd_data = r_rd_pat ? r_rd_patval : r_rd_raw;

    // Capture pattern selection alongside each issued read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pat    <= 1'b0;
            r_rd_patval <= '0;
        end else if (ce && w_rd_issue) begin
            r_rd_pat    <= pattern_en;
            r_rd_patval <= DW'(w_pat);
        end
    end
`else
    assign w_rd_data = r_rd_raw;
`endif

    // Bank occupancy after this cycle's write completion and read release
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) begin
            w_full_nxt[r_wbank] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rbank] = 1'b0;
        end
        w_wbank_nxt = r_wbank ^ w_wr_done;
    end

    // Write pointer, bank flags, lengths and overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wbank    <= 1'b0;
            r_wa       <= '0;
            r_full     <= 2'b00;
            r_len[0]   <= '0;
            r_len[1]   <= '0;
            r_overflow <= 1'b0;
            r_wr_ready <= 1'b1;
        end else if (ce) begin
            r_full     <= w_full_nxt;
            r_wbank    <= w_wbank_nxt;
            r_wr_ready <= ~w_full_nxt[w_wbank_nxt];
            if (w_wr_fire) begin
                r_wa <= w_wr_done ? '0 : r_wa + AW'(1);
            end
            if (w_wr_done) begin
                r_len[r_wbank] <= LW'(r_wa) + LW'(1);
            end
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // BRAM: one write port, one registered read port
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[{r_wbank, r_wa}] <= wr_data;
        end
        if (ce && w_rd_issue) begin
            r_rd_raw <= r_mem[{r_rbank, r_ra[AW-1:0]}];
        end
    end

    // Transmit FSM, read issue and two-entry output skid buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_rbank      <= 1'b0;
            r_ra         <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_rd_user    <= 1'b0;
            r_rd_last    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_user   <= 1'b0;
            r_out_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_user  <= 1'b0;
            r_skid_last  <= 1'b0;
        end else if (ce) begin
            r_frame_done <= 1'b0;
            r_rd_vld     <= w_rd_issue;
            if (w_rd_issue) begin
                r_ra      <= r_ra + LW'(1);
                r_rd_user <= (r_ra == '0);
                r_rd_last <= (r_ra == r_len[r_rbank] - LW'(1));
            end

            if (!r_out_valid || w_pop) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_user   <= r_skid_user;
                    r_out_last   <= r_skid_last;
                    r_skid_valid <= r_rd_vld;
                    if (r_rd_vld) begin
                        r_skid_data <= w_rd_data;
                        r_skid_user <= r_rd_user;
                        r_skid_last <= r_rd_last;
                    end
                end else if (r_rd_vld) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_rd_data;
                    r_out_user  <= r_rd_user;
                    r_out_last  <= r_rd_last;
                end else begin
                    r_out_valid <= 1'b0;
                    r_out_user  <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            end else if (r_rd_vld) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_rd_data;
                r_skid_user  <= r_rd_user;
                r_skid_last  <= r_rd_last;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_oneshot || start_cont) begin
                        r_state <= S_WAITF;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAITF: begin
                    if (r_full[r_rbank]) begin
                        r_ra    <= '0;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_pop && r_out_last) begin
                        r_rbank      <= ~r_rbank;
                        r_frame_done <= 1'b1;
                        r_state      <= start_cont ? S_WAITF : S_IDLE;
                        r_busy       <= start_cont;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready        = r_wr_ready;
    assign busy            = r_busy;
    assign frame_done      = r_frame_done;
    assign overflow        = r_overflow;
    assign m_axis.tvalid_m = r_out_valid;
    assign m_axis.tdata_m  = r_out_data;
    assign m_axis.tuser_m  = r_out_user;
    assign m_axis.tlast_m  = r_out_last;

endmodule

// File: doc/frame_stream_source.md
Name: frame_stream_source

Overview:
- AXI-Stream master that plays captured frames into the DSP analysis chain; it is the transmit end of the stream interface that prominence/peak analysers consume.
- A simple write port fills a ping-pong pair of BRAM banks.
- Each completed bank is replayed as one frame: tuser on the first beat, tlast on the last beat, with full tready back-pressure.
- Sits between the capture/FFT magnitude path and stream consumers.

Parameters:
- DW, 16, sample width (signed, passed through unchanged)
- AW, 10, bank address width; bank depth = 2^AW words

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- ce  in  1  clock enable; all state frozen when low
- wr_data  in  DW  sample to store
- wr_valid  in  1  write strobe
- wr_last  in  1  last sample of the current frame
- wr_ready  out  1  write bank available
- tdata_m  out  DW  stream data
- tuser_m  out  1  first beat of frame
- tlast_m  out  1  last beat of frame
- tvalid_m  out  1  stream valid
- tready_m  in  1  stream ready
- start_oneshot  in  1  transmit one frame
- start_cont  in  1  transmit frames continuously while high
- busy  out  1  FSM not in IDLE
- frame_done  out  1  one-cycle pulse when the final beat is accepted
- overflow  out  1  sticky: a write was dropped
- clr_overflow  in  1  clears overflow

Behaviour:
- Reset values: wr_ready=1, tvalid_m=0, tuser_m=0, tlast_m=0, tdata_m=0, busy=0, frame_done=0, overflow=0. Both banks empty; wbank=0, rbank=0.
- Reset mid-frame aborts the frame and discards both banks.
- Write side (all updates qualified by ce):
  - wr_ready = !full[wbank].
  - On wr_valid&&wr_ready: mem[wbank][wa] <= wr_data; wa increments.
  - If wr_last, or wa==2^AW-1: len[wbank] <= wa+1, full[wbank] <= 1, wbank toggles, wa <= 0. A frame therefore wraps at depth.
  - wr_valid&&!wr_ready: the sample is dropped and overflow <= 1.
  - clr_overflow clears overflow. If it coincides with a drop, the set wins.
- Transmit FSM states:
  - IDLE: on start_oneshot||start_cont, go to WAITF. start_oneshot is sampled only here.
  - WAITF: when full[rbank], set ra <= 0 and go to STREAM.
  - STREAM:
    - Issue reads ra=0..len-1 into a 2-entry output skid buffer; one BRAM read latency.
    - First tvalid_m occurs 2 cycles after entering STREAM.
    - Sustains 1 beat/cycle while tready_m is high.
    - A read is issued only while the skid buffer has a free slot after accounting for the read in flight; no beat is lost or duplicated.
    - tuser_m=1 only on the beat for ra=0; tlast_m=1 only on the beat for ra=len-1. Both are 1 when len=1.
  - Last-beat acceptance (tvalid_m&&tready_m&&tlast_m): full[rbank] <= 0, rbank toggles, frame_done pulses. Next state is WAITF if start_cont is high that cycle, else IDLE.
- AXI rules:
  - Once tvalid_m is high, tdata_m/tuser_m/tlast_m are held until accepted.
  - tvalid_m never depends combinationally on tready_m.
- Simultaneous events:
  - A writer completing one bank in the same cycle the reader releases the other bank: both updates apply.
  - The writer never targets a full bank, so a write/read conflict on the same bank cannot occur.
  - Deasserting start_cont mid-frame: the current frame completes, then the FSM returns to IDLE.
- ce low: FSM, pointers, BRAM and outputs frozen, including tvalid_m. Handshakes count only when ce is high.

Optional Feature:
- Macro: FRAME_SOURCE_PATTERN_EN.
- When defined: adds input pattern_en (1 bit). While high, tdata_m carries a triangular test pattern in place of BRAM data: +1 per beat from 0 up to len/2, then -1 per beat. Framing, length and handshakes are unchanged. This exercises peak detection without capture hardware.
- When undefined: the port is absent and the data is always BRAM contents.

Test Plan:
- Write 8 samples 0..7 with wr_last on 7, pulse start_oneshot, hold tready_m=1 -> 8 consecutive beats 0..7; tuser on beat 0; tlast on beat 7; frame_done once; busy returns to 0.
- Same frame, tready_m toggling 1010... -> identical beat sequence; data held stable during stalls; no duplicates.
- Write a 1-sample frame (value -5), start_oneshot -> a single beat -5 with tuser=tlast=1.
- Fill both banks (lengths 4 and 6) with no start, then write one more sample -> sample dropped, overflow=1. Pulse clr_overflow -> overflow=0.
- Hold start_cont high with the writer continuously supplying 16-sample frames -> back-to-back frames alternating banks; each frame's first beat has tuser=1. Drop start_cont mid-frame -> the frame completes, then IDLE.
- Assert reset_n=0 mid-stream at beat 3 -> all outputs return to reset values immediately; after release, banks are empty and wr_ready=1.
